// File: rtl/payload_rr_arbiter.sv
// Packet-locked round-robin arbiter for a shared payload path.
// A granted PE keeps the path until its last beat; priority then rotates past it.
module payload_rr_arbiter #(
  parameter int NUM_PE = 10,
  localparam int IDX_W = $clog2(NUM_PE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_PE-1:0] enables,
  input  logic [NUM_PE-1:0] last,
  output logic [IDX_W-1:0]  current,
  output logic              enable_arbiter
);

  logic              busy_reg;
  logic [IDX_W-1:0]  owner_reg;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  current_reg;
  logic              enable_arbiter_reg;

  logic              grant_valid_next;
  logic [IDX_W-1:0]  grant_idx_next;
  logic [IDX_W-1:0]  ptr_next;

  // Scan position gi maps to PE (ptr + gi) mod NUM_PE.
  logic [IDX_W-1:0]  cand_idx [NUM_PE];
  logic [NUM_PE-1:0] cand_req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_scan
      logic [IDX_W:0] sum;
      assign sum = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_PE)) ?
                            IDX_W'(sum - (IDX_W+1)'(NUM_PE)) : sum[IDX_W-1:0];
      assign cand_req[gi] = enables[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    grant_valid_next = 1'b0;
    grant_idx_next   = owner_reg;
    if (busy_reg) begin
      grant_valid_next = enables[owner_reg];
    end else begin
      // Walk downward so the lowest scan offset wins.
      for (int k = NUM_PE - 1; k >= 0; k--) begin
        if (cand_req[k]) begin
          grant_valid_next = 1'b1;
          grant_idx_next   = cand_idx[k];
        end
      end
    end
  end

  assign ptr_next = (grant_idx_next == IDX_W'(NUM_PE - 1)) ? '0
                                                           : grant_idx_next + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg           <= 1'b0;
      owner_reg          <= '0;
      ptr_reg            <= '0;
      current_reg        <= '0;
      enable_arbiter_reg <= 1'b0;
    end else begin
      enable_arbiter_reg <= grant_valid_next;
      if (grant_valid_next) begin
        current_reg <= grant_idx_next;
        if (last[grant_idx_next]) begin
          busy_reg <= 1'b0;
          ptr_reg  <= ptr_next;
        end else begin
          busy_reg  <= 1'b1;
          owner_reg <= grant_idx_next;
        end
      end
    end
  end

  assign current        = current_reg;
  assign enable_arbiter = enable_arbiter_reg;

endmodule

// File: tb/tb_payload_rr_arbiter.sv
// Directed and randomized checks of payload_rr_arbiter against a
// packet-level round-robin reference model.
module tb_payload_rr_arbiter;

  localparam int N   = 10;
  localparam int IDX = $clog2(N);

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   enables;
  logic [N-1:0]   last;
  logic [IDX-1:0] current;
  logic           enable_arbiter;

  int pass_count  = 0;
  int check_count = 0;

  // Reference model state
  int m_busy, m_owner, m_ptr, m_cur, m_en;

  payload_rr_arbiter #(.NUM_PE(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enables        (enables),
    .last           (last),
    .current        (current),
    .enable_arbiter (enable_arbiter)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cur = 0; m_en = 0;
  endfunction

  function automatic void model_update(input logic [N-1:0] e, input logic [N-1:0] l);
    int g;
    g = -1;
    if (m_busy != 0) begin
      if (e[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_ptr + k) % N;
        if (g < 0 && e[i]) g = i;
      end
    end
    if (g < 0) begin
      m_en = 0;
    end else begin
      m_en  = 1;
      m_cur = g;
      if (l[g]) begin
        m_busy = 0;
        m_ptr  = (g + 1) % N;
      end else begin
        m_busy  = 1;
        m_owner = g;
      end
    end
  endfunction

  // One transaction: drive inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [N-1:0] e, input logic [N-1:0] l);
    enables = e;
    last    = l;
    @(posedge clk);
    model_update(e, l);
    #1;
    $display("t=%0t enables=%b last=%b -> current=%0d enable_arbiter=%b",
             $time, e, l, current, enable_arbiter);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    enables = 10'b1011001101;
    last    = 10'b0110010011;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_count++;
    if (current !== 4'd0 || enable_arbiter !== 1'b0)
      $display("FAIL reset_async: current=%0d enable_arbiter=%b, want 0/0", current, enable_arbiter);
    else pass_count++;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      step('0, '0);
      check_count++;
      if (current !== 4'd0 || enable_arbiter !== 1'b0)
        $display("FAIL reset_idle: current=%0d enable_arbiter=%b, want 0/0", current, enable_arbiter);
      else pass_count++;
    end
  endtask

  task automatic test_lock();
    step(10'b0100000000, '0);
    check_count++;
    if (current !== 4'd8 || enable_arbiter !== 1'b1)
      $display("FAIL lock_grant: current=%0d enable_arbiter=%b, want 8/1", current, enable_arbiter);
    else pass_count++;
    step(10'b0001000000, '0);
    check_count++;
    if (current !== 4'd8 || enable_arbiter !== 1'b0)
      $display("FAIL lock_stall: current=%0d enable_arbiter=%b, want 8/0", current, enable_arbiter);
    else pass_count++;
  endtask

  task automatic test_release_rotation();
    step(10'b0101000000, 10'b0100000000);
    check_count++;
    if (current !== 4'd8 || enable_arbiter !== 1'b1)
      $display("FAIL release_last: current=%0d enable_arbiter=%b, want 8/1", current, enable_arbiter);
    else pass_count++;
    step(10'b0001000010, '0);
    check_count++;
    if (current !== 4'd1 || enable_arbiter !== 1'b1)
      $display("FAIL rotation: current=%0d enable_arbiter=%b, want 1/1", current, enable_arbiter);
    else pass_count++;
    step(10'b0000000010, 10'b0000000010);
    check_count++;
    if (current !== 4'd1 || enable_arbiter !== 1'b1)
      $display("FAIL rotation_finish: current=%0d enable_arbiter=%b, want 1/1", current, enable_arbiter);
    else pass_count++;
  endtask

  task automatic test_wrap();
    pulse_reset();
    step(10'b1000000000, 10'b1000000000);
    check_count++;
    if (current !== 4'd9 || enable_arbiter !== 1'b1)
      $display("FAIL wrap_grant9: current=%0d enable_arbiter=%b, want 9/1", current, enable_arbiter);
    else pass_count++;
    step(10'b1000000001, '0);
    check_count++;
    if (current !== 4'd0 || enable_arbiter !== 1'b1)
      $display("FAIL wrap_to0: current=%0d enable_arbiter=%b, want 0/1", current, enable_arbiter);
    else pass_count++;
    step(10'b1000000001, 10'b0000000001);
    check_count++;
    if (current !== 4'd0 || enable_arbiter !== 1'b1)
      $display("FAIL wrap_locked: current=%0d enable_arbiter=%b, want 0/1", current, enable_arbiter);
    else pass_count++;
  endtask

  task automatic test_idle_single_beat();
    for (int c = 0; c < 3; c++) begin
      step('0, 10'b1111111111);
      check_count++;
      if (current !== 4'd0 || enable_arbiter !== 1'b0)
        $display("FAIL idle_hold: current=%0d enable_arbiter=%b, want 0/0", current, enable_arbiter);
      else pass_count++;
    end
    step(10'b0000000100, 10'b0000000100);
    check_count++;
    if (current !== 4'd2 || enable_arbiter !== 1'b1)
      $display("FAIL single_beat: current=%0d enable_arbiter=%b, want 2/1", current, enable_arbiter);
    else pass_count++;
    step(10'b0000001000, '0);
    check_count++;
    if (current !== 4'd3 || enable_arbiter !== 1'b1)
      $display("FAIL single_beat_unlocked: current=%0d enable_arbiter=%b, want 3/1", current, enable_arbiter);
    else pass_count++;
    step(10'b0000001000, 10'b0000001000);
    step('0, '0);
    check_count++;
    if (current !== 4'd3 || enable_arbiter !== 1'b0)
      $display("FAIL single_beat_drop: current=%0d enable_arbiter=%b, want 3/0", current, enable_arbiter);
    else pass_count++;
  endtask

  task automatic test_reset_mid_packet();
    step(10'b0000100000, '0);
    check_count++;
    if (current !== 4'd5 || enable_arbiter !== 1'b1)
      $display("FAIL midpkt_lock: current=%0d enable_arbiter=%b, want 5/1", current, enable_arbiter);
    else pass_count++;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_count++;
    if (current !== 4'd0 || enable_arbiter !== 1'b0)
      $display("FAIL midpkt_reset: current=%0d enable_arbiter=%b, want 0/0", current, enable_arbiter);
    else pass_count++;
    #1;
    rst_n = 1'b1;
    step(10'b0000100001, '0);
    check_count++;
    if (current !== 4'd0 || enable_arbiter !== 1'b1)
      $display("FAIL midpkt_restart: current=%0d enable_arbiter=%b, want 0/1", current, enable_arbiter);
    else pass_count++;
    step(10'b0000000001, 10'b0000000001);
  endtask

  task automatic test_random();
    logic [N-1:0] e, l;
    for (int c = 0; c < 400; c++) begin
      e = N'($urandom & $urandom);
      if ($urandom_range(0, 7) == 0) e = '0;
      l = N'($urandom & $urandom);
      step(e, l);
      check_count++;
      if (current !== IDX'(m_cur) || enable_arbiter !== m_en[0])
        $display("FAIL random_%0d: current=%0d enable_arbiter=%b, want %0d/%0d",
                 c, current, enable_arbiter, m_cur, m_en);
      else pass_count++;
      if ($urandom_range(0, 63) == 0) pulse_reset();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_lock();
    test_release_rotation();
    test_wrap();
    test_idle_single_beat();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/payload_rr_arbiter.md
Name: payload_rr_arbiter

Overview:
- Round-robin arbiter that grants one of NUM_PE processing elements (PEs) access to a shared payload path.
- Each PE raises an enable bit to request the path and a last bit to mark the final beat of its packet.
- Once a PE is granted, it keeps ownership until it delivers its last beat (packet lock). The arbiter then rotates priority.
- Sits between the PE array and the payload mux/bus. `current` drives the mux select; `enable_arbiter` qualifies it.

Parameters:
- NUM_PE, default 10: number of requesting PEs; must be >= 2.
- IDX_W, default $clog2(NUM_PE) (4 for default): width of the PE index. Derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- enables  input  NUM_PE  per-PE request/beat-valid; bit i = PE i has a payload beat this cycle.
- last  input  NUM_PE  per-PE last-beat flag; meaningful only when the matching enables bit is 1.
- current  output  IDX_W  index of the PE granted at the most recent grant; registered.
- enable_arbiter  output  1  high for one cycle per granted beat; registered.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - current=0, enable_arbiter=0.
  - lock flag cleared, owner=0, round-robin pointer ptr=0.
- State registers: busy (lock flag), owner[IDX_W-1:0], ptr[IDX_W-1:0], plus the two outputs.
- Combinational grant selection each cycle:
  - If busy: candidate = owner; valid only if enables[owner]=1. All other requests are ignored.
  - If not busy: scan indices ptr, ptr+1, …, NUM_PE-1, 0, …, ptr-1, wrapping modulo NUM_PE. The first index with enables=1 is the candidate. No enables bit set means no grant.
- On each rising edge:
  - Valid grant g: enable_arbiter<=1, current<=g.
    - If last[g]=1: busy<=0, ptr<=(g+1) mod NUM_PE. Wrap: g=NUM_PE-1 gives ptr=0.
    - If last[g]=0: busy<=1, owner<=g.
  - No valid grant: enable_arbiter<=0; current, busy, owner and ptr hold.
- Latency: a request sampled at edge N appears on current/enable_arbiter after edge N (one-cycle registered latency).
- Single-beat packet: enables[i]=1 with last[i]=1 while idle → granted and released in the same cycle.
- While locked, an owner that drops its enable stalls the bus. enable_arbiter=0, lock kept, no other PE served.
- last bits for non-enabled or non-granted PEs are ignored.
- ptr only advances on packet completion, giving packet-level fairness.
- Reset asserted mid-packet aborts the lock immediately; after release, arbitration restarts from PE 0.
- Combinational logic only on internal next-state. No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n=0 with arbitrary inputs → current=0, enable_arbiter=0 immediately, without waiting for a clock; after release with enables=0 → outputs remain 0.
- Lock acquisition: enables=10'b0100000000, last=0 → next edge current=8, enable_arbiter=1. Following cycle enables=10'b0001000000 (PE 6 only) → enable_arbiter=0, current stays 8.
- Release and rotation: while locked to 8, enables=10'b0101000000 with last[8]=1 → current=8, enable_arbiter=1, lock released, ptr=9. Next cycle enables=10'b0001000010 → current=1, because the scan 9→0→1 finds PE 1 before PE 6.
- Wrap-around: while idle with ptr=0, enables bit 9 only with last[9]=1 → current=9; next cycle enables bits 0 and 9, last=0 → current=0.
- Idle and single-beat: enables=0 for several cycles → enable_arbiter=0 and current held. Then enables=10'b0000000100 with last=10'b0000000100 → current=2, enable_arbiter=1 for exactly one cycle, not locked. Next cycle enables=10'b0000001000 → current=3.
- Reset mid-packet: lock on PE 5, then pulse rst_n low → outputs 0 and lock cleared. After release, enables=10'b0000100001 → current=0.
